// File: rtl/top_module_impl.sv
// Free-running 8x8 image-processing demonstrator: raster-scans a fixed ROM image
// and registers eight per-pixel results (point ops, gradients, 3x3 box mean).
module top_module_impl (
  input  logic       CLK,
  input  logic       RST,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic [7:0] out4,
  output logic [7:0] out5,
  output logic [7:0] out6,
  output logic [7:0] out7,
  output logic [7:0] out8
);

  logic [5:0]      addr_q, addr_d;
  logic [7:0][7:0] res_q, res_d;

  logic [2:0]      r, c, rm, rp, cm, cp;
  logic [2:0][2:0] rows, cols;
  logic [7:0]      p;
  logic [11:0]     sum;

  // Test image P(r,c) = r*32 + c*4
  function automatic logic [7:0] pix(input logic [2:0] pr, input logic [2:0] pc);
    return {pr, 5'b0} + {3'b0, pc, 2'b0};
  endfunction

  function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[8] ? 8'(-d) : d[7:0];
  endfunction

  always_comb begin
    r  = addr_q[5:3];
    c  = addr_q[2:0];
    // Replicate padding at the image border
    rm = (r == 3'd0) ? 3'd0 : r - 3'd1;
    rp = (r == 3'd7) ? 3'd7 : r + 3'd1;
    cm = (c == 3'd0) ? 3'd0 : c - 3'd1;
    cp = (c == 3'd7) ? 3'd7 : c + 3'd1;
    rows = {rp, r, rm};
    cols = {cp, c, cm};

    sum = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        sum = sum + {4'b0, pix(rows[i], cols[j])};

    p = pix(r, c);
    res_d[0] = p;
    res_d[1] = 8'd255 - p;
    res_d[2] = (p >= 8'd192) ? 8'd255 : p + 8'd64;
    res_d[3] = (p >= 8'd64)  ? p - 8'd64 : 8'd0;
    res_d[4] = p[7] ? 8'd255 : 8'd0;
    res_d[5] = absdiff(pix(r, cp), pix(r, cm));
    res_d[6] = absdiff(pix(rp, c), pix(rm, c));
    res_d[7] = 8'(sum / 12'd9);

    addr_d = addr_q + 6'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q <= '0;
      res_q  <= '0;
    end else begin
      addr_q <= addr_d;
      res_q  <= res_d;
    end
  end

  assign out1 = res_q[0];
  assign out2 = res_q[1];
  assign out3 = res_q[2];
  assign out4 = res_q[3];
  assign out5 = res_q[4];
  assign out6 = res_q[5];
  assign out7 = res_q[6];
  assign out8 = res_q[7];

endmodule

// File: tb/tb_top_module_impl.sv
// Directed bench for top_module_impl: hand-computed pixel vectors, a full-frame
// reference model, frame-to-frame repeat check and mid-frame reset.
module tb_top_module_impl;

  logic       CLK, RST;
  logic [7:0] out1, out2, out3, out4, out5, out6, out7, out8;

  int checks = 0;
  int errors = 0;

  top_module_impl dut (
    .CLK(CLK), .RST(RST),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4),
    .out5(out5), .out6(out6), .out7(out7), .out8(out8)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int              k;
    logic [7:0][7:0] exp;
  } vec_t;

  vec_t            tbl[10];
  logic [7:0][7:0] frame1[64];

  function automatic logic [7:0][7:0] mk(int o1, int o2, int o3, int o4,
                                          int o5, int o6, int o7, int o8);
    logic [7:0][7:0] v;
    v[0] = 8'(o1); v[1] = 8'(o2); v[2] = 8'(o3); v[3] = 8'(o4);
    v[4] = 8'(o5); v[5] = 8'(o6); v[6] = 8'(o7); v[7] = 8'(o8);
    return v;
  endfunction

  function automatic int clampi(int x);
    return (x < 0) ? 0 : (x > 7) ? 7 : x;
  endfunction

  function automatic int img(int r, int c);
    return clampi(r) * 32 + clampi(c) * 4;
  endfunction

  function automatic int iabs(int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic logic [7:0][7:0] model(int k);
    int r, c, pv, s;
    r = k / 8;
    c = k % 8;
    pv = img(r, c);
    s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        s += img(r + dr, c + dc);
    return mk(pv, 255 - pv, (pv + 64 > 255) ? 255 : pv + 64,
              (pv < 64) ? 0 : pv - 64, (pv >= 128) ? 255 : 0,
              iabs(img(r, c + 1) - img(r, c - 1)),
              iabs(img(r + 1, c) - img(r - 1, c)), s / 9);
  endfunction

  function automatic logic [7:0][7:0] actual();
    return {out8, out7, out6, out5, out4, out3, out2, out1};
  endfunction

  task automatic chk8(input string tag, input logic [7:0][7:0] exp);
    logic [7:0][7:0] act;
    act = actual();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (act[i] !== exp[i]) begin
        errors++;
        $display("FAIL %s out%0d got %0d expected %0d", tag, i + 1, act[i], exp[i]);
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    tbl[0] = '{0,  mk(0,   255, 64,  0,   0,   4, 32, 12)};
    tbl[1] = '{28, mk(112, 143, 176, 48,  0,   8, 64, 112)};
    tbl[2] = '{63, mk(252, 3,   255, 188, 255, 4, 32, 240)};
    tbl[3] = '{7,  mk(28,  227, 92,  0,   0,   4, 32, 37)};
    tbl[4] = '{56, mk(224, 31,  255, 160, 255, 4, 32, 214)};
    tbl[5] = '{9,  mk(36,  219, 100, 0,   0,   8, 64, 36)};
    tbl[6] = '{32, mk(128, 127, 192, 64,  255, 4, 64, 129)};
    tbl[7] = '{31, mk(124, 131, 188, 60,  0,   4, 64, 122)};
    tbl[8] = '{16, mk(64,  191, 128, 0,   0,   4, 64, 65)};
    tbl[9] = '{48, mk(192, 63,  255, 128, 255, 4, 64, 193)};

    RST = 1'b1;
    step();
    step();
    chk8("reset", '0);

    // Frame 1: hand vectors plus reference model on every pixel
    RST = 1'b0;
    for (int k = 0; k < 64; k++) begin
      step();
      frame1[k] = actual();
      for (int t = 0; t < 10; t++)
        if (tbl[t].k == k) chk8($sformatf("vec_k%0d", k), tbl[t].exp);
      chk8($sformatf("model_k%0d", k), model(k));
    end

    // Frame 2 must repeat frame 1 exactly
    for (int k = 0; k < 64; k++) begin
      step();
      chk8($sformatf("frame2_k%0d", k), frame1[k]);
    end

    // Frame 3: reset while pixel 20 is due
    for (int k = 0; k < 20; k++) step();
    chk8("pre_reset_k19", model(19));
    RST = 1'b1;
    step();
    chk8("midreset", '0);
    RST = 1'b0;
    step();
    chk8("restart_k0", tbl[0].exp);
    step();
    chk8("restart_k1", model(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
